// File: rtl/io_bus_responder_if.sv
// Processor-side I/O bus bundle for io_bus_responder.
// master = processor core, slave = responder.
interface io_bus_responder_if;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        IOSel;
    logic [31:0] IORdData;

    modport master (
        output Adr,
        output WriteData,
        output MemWrite,
        input  IOSel,
        input  IORdData
    );

    modport slave (
        input  Adr,
        input  WriteData,
        input  MemWrite,
        output IOSel,
        output IORdData
    );
endinterface

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder: byte TX FIFO plus a
// reloading down-counter timer with sticky expired/irq.
module io_bus_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          DEPTH     = 4
) (
    input  logic                clk,
    input  logic                reset,
    io_bus_responder_if.slave   bus,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   tload_q, tload_d;
    logic [31:0]   tcount_q, tcount_d;
    logic          en_q, en_d;
    logic          exp_q, exp_d;

    logic        wr_en, wr_tx, wr_st, wr_tl, wr_tc;
    logic        full, empty, push, pop, set_exp;
    logic [31:0] wd;
    logic [31:0] status;

    assign wd        = bus.WriteData;
    assign bus.IOSel = (bus.Adr[31:5] == BASE_ADDR[31:5]);
    assign wr_en     = bus.IOSel & bus.MemWrite
                     & (bus.Adr[1:0] == 2'b00);
    assign wr_tx     = wr_en & (bus.Adr[4:2] == 3'd0);
    assign wr_st     = wr_en & (bus.Adr[4:2] == 3'd1);
    assign wr_tl     = wr_en & (bus.Adr[4:2] == 3'd2);
    assign wr_tc     = wr_en & (bus.Adr[4:2] == 3'd3);

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign tx_valid = ~empty;
    assign tx_data  = mem_q[rptr_q];
    assign pop      = tx_valid & tx_ready;
    // A concurrent pop frees the slot, so a full FIFO still accepts.
    assign push     = wr_tx & (~full | pop);
    assign irq      = exp_q & en_q;

    assign status = {23'd0, 5'(count_q), exp_q, ovf_q, empty, full};

    always_comb begin
        bus.IORdData = 32'd0;
        if (bus.IOSel) begin
            case (bus.Adr[4:0])
                5'h04:   bus.IORdData = status;
                5'h08:   bus.IORdData = tload_q;
                5'h0C:   bus.IORdData = {31'd0, en_q};
                5'h10:   bus.IORdData = tcount_q;
                default: bus.IORdData = 32'd0;
            endcase
        end
    end

    always_comb begin
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q;
        unique case (1'b1)
            push & ~pop: count_d = count_q + CW'(1);
            pop & ~push: count_d = count_q - CW'(1);
            default:     count_d = count_q;
        endcase

        ovf_d = ovf_q;
        if (wr_st & wd[2])
            ovf_d = 1'b0;
        if (wr_tx & full & ~pop)
            ovf_d = 1'b1;
    end

    always_comb begin
        tload_d  = tload_q;
        tcount_d = tcount_q;
        en_d     = en_q;
        exp_d    = exp_q;
        set_exp  = 1'b0;
        if (wr_tl) begin
            tload_d  = wd;
            tcount_d = wd;
        end else if (en_q) begin
            if (tcount_q != 32'd0) begin
                tcount_d = tcount_q - 32'd1;
            end else begin
                tcount_d = tload_q;
                set_exp  = 1'b1;
            end
        end
        if (wr_tc)
            en_d = wd[0];
        // Set beats a same-cycle software clear.
        if (wr_st & wd[3])
            exp_d = 1'b0;
        if (set_exp)
            exp_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= wd[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            tload_q  <= 32'd0;
            tcount_q <= 32'd0;
            en_q     <= 1'b0;
            exp_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            tload_q  <= tload_d;
            tcount_q <= tcount_d;
            en_q     <= en_d;
            exp_q    <= exp_d;
        end
    end

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed vector bench for io_bus_responder.
module tb_io_bus_responder;

    localparam logic [31:0] TX  = 32'hFFFF_FF00;
    localparam logic [31:0] ST  = 32'hFFFF_FF04;
    localparam logic [31:0] TL  = 32'hFFFF_FF08;
    localparam logic [31:0] TC  = 32'hFFFF_FF0C;
    localparam logic [31:0] CNT = 32'hFFFF_FF10;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] rd;
        logic        vld;
        logic [7:0]  dat;
        logic        irq;
        logic        sel;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       irq;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];

    io_bus_responder_if bus ();

    io_bus_responder dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic drive(logic we, logic [31:0] adr, logic [31:0] wd,
                         logic rdy, logic rst);
        @(negedge clk);
        bus.MemWrite  = we;
        bus.Adr       = adr;
        bus.WriteData = wd;
        tx_ready      = rdy;
        reset         = rst;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(logic we, logic [31:0] adr,
                                logic [31:0] wd, logic rdy,
                                logic [31:0] rd, logic vld,
                                logic [7:0] dat, logic ir, logic sel);
        vec_t v;
        v.we = we; v.adr = adr; v.wd = wd; v.rdy = rdy;
        v.rd = rd; v.vld = vld; v.dat = dat; v.irq = ir; v.sel = sel;
        tbl.push_back(v);
    endfunction

    initial begin
        // reset state and address decode
        add(0, ST,  0, 0, 32'h02, 0, 0, 0, 1);
        add(0, 32'h40, 0, 0, 32'h00, 0, 0, 0, 0);
        // fill FIFO with ready low, fifth byte overflows
        add(1, TX, 32'h41, 0, 0, 1, 8'h41, 0, 1);
        add(1, TX, 32'h42, 0, 0, 1, 8'h41, 0, 1);
        add(1, TX, 32'h43, 0, 0, 1, 8'h41, 0, 1);
        add(1, TX, 32'h44, 0, 0, 1, 8'h41, 0, 1);
        add(1, TX, 32'h45, 0, 0, 1, 8'h41, 0, 1);
        add(0, ST, 0, 0, 32'h45, 1, 8'h41, 0, 1);
        // drain in order
        add(0, ST, 0, 1, 32'h34, 1, 8'h42, 0, 1);
        add(0, ST, 0, 1, 32'h24, 1, 8'h43, 0, 1);
        add(0, ST, 0, 1, 32'h14, 1, 8'h44, 0, 1);
        add(0, ST, 0, 1, 32'h06, 0, 0, 0, 1);
        add(1, ST, 32'h4, 0, 32'h02, 0, 0, 0, 1);
        // push into full FIFO with concurrent pop
        add(1, TX, 32'h61, 0, 0, 1, 8'h61, 0, 1);
        add(1, TX, 32'h62, 0, 0, 1, 8'h61, 0, 1);
        add(1, TX, 32'h63, 0, 0, 1, 8'h61, 0, 1);
        add(1, TX, 32'h64, 0, 0, 1, 8'h61, 0, 1);
        add(1, TX, 32'h55, 1, 0, 1, 8'h62, 0, 1);
        add(0, ST, 0, 0, 32'h41, 1, 8'h62, 0, 1);
        add(0, ST, 0, 1, 32'h30, 1, 8'h63, 0, 1);
        add(0, ST, 0, 1, 32'h20, 1, 8'h64, 0, 1);
        add(0, ST, 0, 1, 32'h10, 1, 8'h55, 0, 1);
        add(0, ST, 0, 1, 32'h02, 0, 0, 0, 1);
        // timer load, enable, count down, reload
        add(1, TL, 32'h3, 0, 32'h3, 0, 0, 0, 1);
        add(1, TC, 32'h1, 0, 32'h1, 0, 0, 0, 1);
        add(0, CNT, 0, 0, 32'h2, 0, 0, 0, 1);
        add(0, CNT, 0, 0, 32'h1, 0, 0, 0, 1);
        add(0, CNT, 0, 0, 32'h0, 0, 0, 0, 1);
        add(0, CNT, 0, 0, 32'h3, 0, 0, 1, 1);
        add(0, ST,  0, 0, 32'h0A, 0, 0, 1, 1);
        add(1, ST,  32'h8, 0, 32'h02, 0, 0, 0, 1);
        add(0, CNT, 0, 0, 32'h0, 0, 0, 0, 1);
        add(0, CNT, 0, 0, 32'h3, 0, 0, 1, 1);
        add(1, ST,  32'h8, 0, 32'h02, 0, 0, 0, 1);
        add(0, CNT, 0, 0, 32'h1, 0, 0, 0, 1);
        add(0, CNT, 0, 0, 32'h0, 0, 0, 0, 1);
        // clear in the reload cycle loses to the set
        add(1, ST,  32'h8, 0, 32'h0A, 0, 0, 1, 1);
        // disable mid-count
        add(1, TC,  32'h0, 0, 32'h0, 0, 0, 0, 1);
        add(0, CNT, 0, 0, 32'h2, 0, 0, 0, 1);
        add(0, CNT, 0, 0, 32'h2, 0, 0, 0, 1);
        // unaligned and reserved stores are ignored
        add(1, 32'hFFFF_FF09, 32'h1, 0, 0, 0, 0, 0, 1);
        add(0, TC,  0, 0, 32'h0, 0, 0, 0, 1);
        add(0, TL,  0, 0, 32'h3, 0, 0, 0, 1);
        add(0, CNT, 0, 0, 32'h2, 0, 0, 0, 1);
        add(1, 32'hFFFF_FF14, 32'hFF, 0, 0, 0, 0, 0, 1);
        add(0, ST,  0, 0, 32'h0A, 0, 0, 0, 1);

        bus.MemWrite  = 1'b0;
        bus.Adr       = 32'd0;
        bus.WriteData = 32'd0;
        tx_ready      = 1'b0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            drive(tbl[i].we, tbl[i].adr, tbl[i].wd, tbl[i].rdy, 1'b0);
            chk($sformatf("v%0d.rd", i), bus.IORdData, tbl[i].rd);
            chk($sformatf("v%0d.valid", i), 32'(tx_valid), 32'(tbl[i].vld));
            if (tbl[i].vld)
                chk($sformatf("v%0d.data", i), 32'(tx_data), 32'(tbl[i].dat));
            chk($sformatf("v%0d.irq", i), 32'(irq), 32'(tbl[i].irq));
            chk($sformatf("v%0d.iosel", i), 32'(bus.IOSel), 32'(tbl[i].sel));
        end

        // reset with bytes queued and the timer running
        drive(1, TC, 32'h1, 0, 1'b0);
        drive(1, TX, 32'h11, 0, 1'b0);
        drive(1, TX, 32'h22, 0, 1'b0);
        chk("rst.pre_valid", 32'(tx_valid), 32'h1);
        chk("rst.pre_data", 32'(tx_data), 32'h11);
        drive(1, TX, 32'h33, 1, 1'b1);
        chk("rst.valid", 32'(tx_valid), 32'h0);
        chk("rst.irq", 32'(irq), 32'h0);
        drive(0, CNT, 0, 0, 1'b0);
        chk("rst.tcount", bus.IORdData, 32'h0);
        drive(0, ST, 0, 0, 1'b0);
        chk("rst.status", bus.IORdData, 32'h02);
        chk("rst.valid2", 32'(tx_valid), 32'h0);
        drive(0, TL, 0, 0, 1'b0);
        chk("rst.tload", bus.IORdData, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
